// File: rtl/fifo_mac_pkg.sv
// Shared types and default widths for the FIFO multiply-accumulate drain.
package fifo_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ACC_WIDTH  = 24;

endpackage

// File: rtl/fifo_mac_drain_mac_unit.sv
// Clearable multiply-accumulator; clr wins over en, sum wraps at ACC_WIDTH.
module mac_unit
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;

    assign prod = PW'(a) * PW'(b);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fifo_mac_drain.sv
// Pops DEPTH pairs from two FIFOs in lockstep and accumulates sum(a_i*b_i).
module fifo_mac_drain
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_rden,
    output logic                  b_rden,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rden;
    logic             start_ok;

    // Pops only while both sides have data and the run still needs pairs.
    assign rden = (state_q == RUN) && !a_empty && !b_empty
                  && (issue_cnt_q < DEPTH_C);
    assign start_ok = start && (state_q != RUN);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        rd_vld_d    = rden;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    issue_cnt_d = '0;
                    acc_cnt_d   = '0;
                end
            end
            RUN: begin
                if (rden) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (rd_vld_q) begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_d == DEPTH_C) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            rd_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            rd_vld_q    <= rd_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_ok),
        .en   (rd_vld_q),
        .a    (a_data),
        .b    (b_data),
        .acc  (acc_out)
    );

    assign a_rden = rden;
    assign b_rden = rden;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fifo_mac_drain.sv
// Directed bench: behavioural FIFO pair feeding a 24-bit and a 16-bit drain.
module tb_fifo_mac_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        a_empty, b_empty;
    logic [7:0]  a_data, b_data;
    logic        a_rden, b_rden;
    logic [23:0] acc;
    logic        busy, done;
    logic        a_rden2, b_rden2;
    logic [15:0] acc16;
    logic        busy2, done2;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    int checks = 0;
    int failures = 0;
    int pops, viol, cyc, first_pop, last_pop, n;

    always #5 clk = ~clk;

    fifo_mac_drain #(.DATA_WIDTH(8), .DEPTH(8), .ACC_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_empty(a_empty), .b_empty(b_empty),
        .a_data(a_data), .b_data(b_data),
        .a_rden(a_rden), .b_rden(b_rden),
        .acc_out(acc), .busy(busy), .done(done)
    );

    fifo_mac_drain #(.DATA_WIDTH(8), .DEPTH(8), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_empty(a_empty), .b_empty(b_empty),
        .a_data(a_data), .b_data(b_data),
        .a_rden(a_rden2), .b_rden(b_rden2),
        .acc_out(acc16), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        a_empty = (qa.size() == 0);
        b_empty = (qb.size() == 0);
    endtask

    task automatic push(input logic [7:0] va, input logic [7:0] vb,
                        input bit da, input bit db);
        if (da) qa.push_back(va);
        if (db) qb.push_back(vb);
        upd();
    endtask

    // Samples the pop request before the edge, then updates the FIFO model.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = a_rden;
        if (a_rden !== b_rden) viol++;
        if (a_rden && (a_empty || b_empty)) viol++;
        @(posedge clk);
        #1;
        cyc++;
        if (pop && qa.size() > 0 && qb.size() > 0) begin
            a_data = qa.pop_front();
            b_data = qb.pop_front();
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
        end
        upd();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (!done && cnt < limit) begin
            tick();
            cnt++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_data = '0;
        b_data = '0;
        pops = 0; viol = 0; cyc = 0;
        first_pop = 0; last_pop = 0;
        upd();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", {8'd0, acc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rden", {31'd0, a_rden}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back run: 1..8 times 2.
        for (int i = 1; i <= 8; i++) push(8'(i), 8'd2, 1, 1);
        pops = 0;
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(40, n);
        chk("t1_latency", n, 32'd9);
        chk("t1_pops", pops, 32'd8);
        chk("t1_consec", last_pop - first_pop, 32'd7);
        chk("t1_acc", {8'd0, acc}, 32'd72);
        chk("t1_empty", {30'd0, a_empty, b_empty}, 32'd3);
        chk("t1_viol", viol, 32'd0);

        // B trickles in with gaps.
        for (int i = 1; i <= 8; i++) push(8'(i), 8'd0, 1, 0);
        pops = 0;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                chk("t2_no_early_done", {31'd0, done}, 32'd0);
                chk("t2_partial", {8'd0, acc}, 32'd56);
            end
            push(8'd0, 8'd2, 0, 1);
            repeat (3) tick();
        end
        wait_done(40, n);
        chk("t2_pops", pops, 32'd8);
        chk("t2_acc", {8'd0, acc}, 32'd72);
        chk("t2_viol", viol, 32'd0);

        // start mid-run is ignored, then restart from DONE.
        for (int i = 1; i <= 8; i++) push(8'(i), 8'd2, 1, 1);
        pops = 0;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        chk("t3_busy_held", {31'd0, busy}, 32'd1);
        wait_done(40, n);
        chk("t3_acc", {8'd0, acc}, 32'd72);
        chk("t3_pops", pops, 32'd8);
        for (int i = 0; i < 8; i++) push(8'd3, 8'd3, 1, 1);
        pops = 0;
        pulse_start();
        chk("t3_clr", {8'd0, acc}, 32'd0);
        chk("t3_rebusy", {30'd0, busy, done}, 32'd2);
        wait_done(40, n);
        chk("t3_acc2", {8'd0, acc}, 32'd72);
        chk("t3_pops2", pops, 32'd8);

        // Full-scale operands: wrap at 16 bits, exact at 24.
        for (int i = 0; i < 8; i++) push(8'hFF, 8'hFF, 1, 1);
        pulse_start();
        wait_done(40, n);
        chk("t4_acc24", {8'd0, acc}, 32'h7F008);
        chk("t4_acc16", {16'd0, acc16}, 32'hF008);
        chk("t4_done16", {31'd0, done2}, 32'd1);
        chk("t4_noX", {31'd0, $isunknown(acc16)}, 32'd0);

        // Asynchronous reset mid-run.
        for (int i = 0; i < 8; i++) push(8'd5, 8'd5, 1, 1);
        pops = 0;
        pulse_start();
        n = 0;
        while (pops < 4 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_four_pops", pops, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("t5_acc", {8'd0, acc}, 32'd0);
        chk("t5_flags", {30'd0, busy, done}, 32'd0);
        chk("t5_rden", {30'd0, a_rden, b_rden}, 32'd0);
        #1;
        rst_n = 1'b1;
        pops = 0;
        repeat (5) tick();
        chk("t5_idle", {30'd0, busy, done}, 32'd0);
        chk("t5_no_pops", pops, 32'd0);
        qa.delete();
        qb.delete();
        upd();

        // Surplus entries stay in the FIFOs.
        for (int i = 0; i < 10; i++) push(8'(i), 8'd1, 1, 1);
        pops = 0;
        pulse_start();
        wait_done(40, n);
        repeat (3) tick();
        chk("t6_pops", pops, 32'd8);
        chk("t6_left_a", qa.size(), 32'd2);
        chk("t6_left_b", qb.size(), 32'd2);
        chk("t6_not_empty", {30'd0, a_empty, b_empty}, 32'd0);
        chk("t6_acc", {8'd0, acc}, 32'd28);
        chk("t6_viol", viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
